// File: rtl/alu_op_decoder.sv
// RV32I integer-ALU decode/issue stage: decodes an instruction into an ALU operation and issues
// it through a two-entry skid buffer (output register + skid register) with valid/ready on both sides.
module alu_op_decoder #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_control,
    output logic [XLEN-1:0] inp1,
    output logic [XLEN-1:0] inp2,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            illegal
);

    localparam logic [6:0] OpcReg   = 7'b0110011;
    localparam logic [6:0] OpcImm   = 7'b0010011;
    localparam logic [6:0] OpcLui   = 7'b0110111;
    localparam logic [6:0] OpcAuipc = 7'b0010111;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluAnd  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluXor  = 4'd4;
    localparam logic [3:0] AluShl  = 4'd5;
    localparam logic [3:0] AluShr  = 4'd6;
    localparam logic [3:0] AluSra  = 4'd7;
    localparam logic [3:0] AluSltu = 4'd8;
    localparam logic [3:0] AluSlt  = 4'd9;

    typedef struct packed {
        logic [3:0]      alu_control;
        logic [XLEN-1:0] inp1;
        logic [XLEN-1:0] inp2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            illegal;
    } op_t;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } state_e;

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = XLEN'($signed(instr[31:20]));
    assign imm_u  = XLEN'($signed({instr[31:12], 12'h000}));
    assign shamt  = XLEN'(instr[24:20]);

    logic            dec_legal;
    logic [3:0]      dec_alu;
    logic [XLEN-1:0] dec_inp1;
    logic [XLEN-1:0] dec_inp2;
    op_t             dec_op;

    always_comb begin
        dec_legal = 1'b0;
        dec_alu   = AluAdd;
        dec_inp1  = '0;
        dec_inp2  = '0;
        case (opcode)
            OpcReg: begin
                dec_inp1 = rs1_data;
                dec_inp2 = rs2_data;
                if (funct7 == F7Base) begin
                    dec_legal = 1'b1;
                    case (funct3)
                        3'b000:  dec_alu = AluAdd;
                        3'b001:  dec_alu = AluShl;
                        3'b010:  dec_alu = AluSlt;
                        3'b011:  dec_alu = AluSltu;
                        3'b100:  dec_alu = AluXor;
                        3'b101:  dec_alu = AluShr;
                        3'b110:  dec_alu = AluOr;
                        default: dec_alu = AluAnd;
                    endcase
                end else if (funct7 == F7Alt && funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_alu   = AluSub;
                end else if (funct7 == F7Alt && funct3 == 3'b101) begin
                    dec_legal = 1'b1;
                    dec_alu   = AluSra;
                end
            end
            OpcImm: begin
                dec_inp1 = rs1_data;
                dec_inp2 = imm_i;
                case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_alu = AluAdd;  end
                    3'b010: begin dec_legal = 1'b1; dec_alu = AluSlt;  end
                    3'b011: begin dec_legal = 1'b1; dec_alu = AluSltu; end
                    3'b100: begin dec_legal = 1'b1; dec_alu = AluXor;  end
                    3'b110: begin dec_legal = 1'b1; dec_alu = AluOr;   end
                    3'b111: begin dec_legal = 1'b1; dec_alu = AluAnd;  end
                    3'b001: begin
                        dec_inp2  = shamt;
                        dec_legal = (funct7 == F7Base);
                        dec_alu   = AluShl;
                    end
                    default: begin
                        dec_inp2  = shamt;
                        dec_legal = (funct7 == F7Base) || (funct7 == F7Alt);
                        dec_alu   = (funct7 == F7Alt) ? AluSra : AluShr;
                    end
                endcase
            end
            OpcLui: begin
                dec_legal = 1'b1;
                dec_inp2  = imm_u;
            end
            OpcAuipc: begin
                dec_legal = 1'b1;
                dec_inp1  = pc;
                dec_inp2  = imm_u;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Illegal words still travel down the pipe, but as a harmless ADD with no write-back.
    always_comb begin
        dec_op = '0;
        if (dec_legal) begin
            dec_op.alu_control = dec_alu;
            dec_op.inp1        = dec_inp1;
            dec_op.inp2        = dec_inp2;
            dec_op.rd          = instr[11:7];
            dec_op.reg_write   = (instr[11:7] != 5'd0);
        end else begin
            dec_op.illegal = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Skid-buffer control FSM
    // ------------------------------------------------------------------------
    state_e state_q, state_d;
    logic   in_ready_q, in_ready_d;
    logic   accept, consume;
    logic   load_out_new, load_out_skid, load_skid;

    assign accept  = in_valid & in_ready_q;
    assign consume = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d      = StOne;
                        load_out_new = 1'b1;
                    end
                end
                StOne: begin
                    if (accept && consume) begin
                        load_out_new = 1'b1;
                    end else if (accept) begin
                        state_d   = StFull;
                        load_skid = 1'b1;
                    end else if (consume) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (consume) begin
                        state_d       = StOne;
                        load_out_skid = 1'b1;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        // Registered ready: depends only on where the buffer will be, never on out_ready now.
        in_ready_d = (state_d != StFull);
    end

    // ------------------------------------------------------------------------
    // Buffer registers and outputs
    // ------------------------------------------------------------------------
    op_t out_q;
    op_t skid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out_new) begin
                out_q <= dec_op;
            end else if (load_out_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec_op;
            end
        end
    end

    always_comb begin
        out_valid   = (state_q != StEmpty);
        in_ready    = in_ready_q;
        alu_control = out_q.alu_control;
        inp1        = out_q.inp1;
        inp2        = out_q.inp2;
        rd          = out_q.rd;
        reg_write   = out_q.reg_write;
        illegal     = out_q.illegal;
    end

endmodule

// File: tb/tb_alu_op_decoder.sv
// Scoreboard bench for alu_op_decoder: accepted instructions push expected ops, a monitor pops
// and compares whenever an output is presented, and checks buffer occupancy every cycle.
module tb_alu_op_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  alu_control;
    logic [31:0] inp1;
    logic [31:0] inp2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;

    always #5 clk = ~clk;

    alu_op_decoder #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .pc         (pc),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_control(alu_control),
        .inp1       (inp1),
        .inp2       (inp2),
        .rd         (rd),
        .reg_write  (reg_write),
        .illegal    (illegal)
    );

    typedef struct packed {
        logic [3:0]  alu;
        logic [31:0] inp1;
        logic [31:0] inp2;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic use_exp = 1'b0;
    exp_t dir_exp = '0;
    exp_t mon_e;

    function automatic exp_t mk(input logic [3:0] a, input logic [31:0] i1, input logic [31:0] i2,
                                input logic [4:0] r, input logic w, input logic il);
        exp_t e;
        e.alu = a; e.inp1 = i1; e.inp2 = i2; e.rd = r; e.rw = w; e.ill = il;
        return e;
    endfunction

    // Reference: instruction semantics straight from the RV32I ALU subset.
    function automatic exp_t model(input logic [31:0] w, input logic [31:0] pcv,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic        ok;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] imm_i;
        f7    = w[31:25];
        f3    = w[14:12];
        imm_i = {{20{w[31]}}, w[31:20]};
        ok    = 1'b1;
        e     = '0;
        e.rd  = w[11:7];
        case (w[6:0])
            7'b0110011: begin
                e.inp1 = a;
                e.inp2 = b;
                case ({f7, f3})
                    {7'h00, 3'd0}: e.alu = 4'd0;
                    {7'h20, 3'd0}: e.alu = 4'd1;
                    {7'h00, 3'd1}: e.alu = 4'd5;
                    {7'h00, 3'd2}: e.alu = 4'd9;
                    {7'h00, 3'd3}: e.alu = 4'd8;
                    {7'h00, 3'd4}: e.alu = 4'd4;
                    {7'h00, 3'd5}: e.alu = 4'd6;
                    {7'h20, 3'd5}: e.alu = 4'd7;
                    {7'h00, 3'd6}: e.alu = 4'd3;
                    {7'h00, 3'd7}: e.alu = 4'd2;
                    default:       ok = 1'b0;
                endcase
            end
            7'b0010011: begin
                e.inp1 = a;
                e.inp2 = imm_i;
                case (f3)
                    3'd0: e.alu = 4'd0;
                    3'd2: e.alu = 4'd9;
                    3'd3: e.alu = 4'd8;
                    3'd4: e.alu = 4'd4;
                    3'd6: e.alu = 4'd3;
                    3'd7: e.alu = 4'd2;
                    3'd1: begin
                        e.inp2 = {27'd0, w[24:20]};
                        e.alu  = 4'd5;
                        ok     = (f7 == 7'h00);
                    end
                    default: begin
                        e.inp2 = {27'd0, w[24:20]};
                        if (f7 == 7'h00)      e.alu = 4'd6;
                        else if (f7 == 7'h20) e.alu = 4'd7;
                        else                  ok = 1'b0;
                    end
                endcase
            end
            7'b0110111: begin e.inp1 = 32'd0; e.inp2 = {w[31:12], 12'h000}; end
            7'b0010111: begin e.inp1 = pcv;   e.inp2 = {w[31:12], 12'h000}; end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e     = '0;
            e.ill = 1'b1;
        end else begin
            e.rw = (e.rd != 5'd0);
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 3);
        case ($urandom_range(0, 9))
            0, 1, 2: w[6:0] = 7'b0110011;
            3, 4, 5: w[6:0] = 7'b0010011;
            6:       w[6:0] = 7'b0110111;
            7:       w[6:0] = 7'b0010111;
            default: ;
        endcase
        if (k < 2)       w[31:25] = 7'h00;
        else if (k == 2) w[31:25] = 7'h20;
        return w;
    endfunction

    task automatic check(input string name, input bit ok, input string got, input string want);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %s, expected %s", name, got, want);
        end
    endtask

    // Input side: record every accepted instruction.
    always begin
        @(negedge clk);
        #1;
        if (!rst && !flush && in_valid && in_ready)
            q.push_back(use_exp ? dir_exp : model(instr, pc, rs1_data, rs2_data));
    end

    // Monitor: occupancy, presented op, consumption and flush handling.
    always begin
        @(negedge clk or posedge rst);
        if (rst) begin
            q.delete();
            #1;
            check("reset", out_valid === 1'b0 && in_ready === 1'b1 && alu_control === 4'd0 &&
                  inp1 === 32'd0 && inp2 === 32'd0 && rd === 5'd0 && reg_write === 1'b0 &&
                  illegal === 1'b0,
                  $sformatf("ov=%b ir=%b alu=%0d i1=%h i2=%h rd=%0d we=%b ill=%b", out_valid,
                            in_ready, alu_control, inp1, inp2, rd, reg_write, illegal),
                  "all zero with in_ready=1");
        end else begin
            check("occupancy", out_valid === (q.size() != 0) && in_ready === (q.size() < 2),
                  $sformatf("out_valid=%b in_ready=%b", out_valid, in_ready),
                  $sformatf("%0d entries buffered", q.size()));
            if (out_valid === 1'b1 && q.size() != 0) begin
                mon_e = q[0];
                check("op", alu_control === mon_e.alu && inp1 === mon_e.inp1 &&
                      inp2 === mon_e.inp2 && (mon_e.ill || rd === mon_e.rd) &&
                      reg_write === mon_e.rw && illegal === mon_e.ill,
                      $sformatf("alu=%0d i1=%h i2=%h rd=%0d we=%b ill=%b", alu_control, inp1,
                                inp2, rd, reg_write, illegal),
                      $sformatf("alu=%0d i1=%h i2=%h rd=%0d we=%b ill=%b", mon_e.alu,
                                mon_e.inp1, mon_e.inp2, mon_e.rd, mon_e.rw, mon_e.ill));
            end
            if (flush) q.delete();
            else if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] p, input logic [31:0] a,
                        input logic [31:0] b, input bit use_e, input exp_t e);
        bit accepted;
        instr = w; pc = p; rs1_data = a; rs2_data = b;
        use_exp = use_e; dir_exp = e; in_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        use_exp  = 1'b0;
        if (!accepted) begin
            $display("FAIL send_timeout: in_ready stayed %b, expected acceptance", in_ready);
            $fatal(1, "input handshake timed out");
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
        if (q.size() != 0) begin
            $display("FAIL drain_timeout: %0d entries left, expected 0", q.size());
            $fatal(1, "output drain timed out");
        end
    endtask

    initial begin
        idle(3);
        rst = 1'b0;
        out_ready = 1'b1;

        send(32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b1, mk(4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0));
        send(32'h40435293, 32'h0, 32'h80000000, 32'd9, 1'b1,
             mk(4'd7, 32'h80000000, 32'd4, 5'd5, 1'b1, 1'b0));
        send(32'h00435293, 32'h0, 32'h80000000, 32'd9, 1'b1,
             mk(4'd6, 32'h80000000, 32'd4, 5'd5, 1'b1, 1'b0));
        send(32'hFFF00093, 32'h0, 32'h1234, 32'd0, 1'b1,
             mk(4'd0, 32'h1234, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0));
        send(32'h12345117, 32'h100, 32'd0, 32'd0, 1'b1,
             mk(4'd0, 32'h100, 32'h12345000, 5'd2, 1'b1, 1'b0));
        send(32'hFFFFFFFF, 32'h0, 32'd1, 32'd2, 1'b1, mk(4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1));
        send(32'h00000013, 32'h0, 32'h55, 32'd0, 1'b1,
             mk(4'd0, 32'h55, 32'd0, 5'd0, 1'b0, 1'b0));
        idle(2);

        // Back-to-back under backpressure: third instruction must wait for FULL to drain.
        out_ready = 1'b0;
        send(32'h00A00093, 32'h0, 32'd3, 32'd4, 1'b0, '0);
        send(32'h40208133, 32'h0, 32'd10, 32'd6, 1'b0, '0);
        fork
            send(32'h0020C1B3, 32'h0, 32'hF0F0, 32'h0FF0, 1'b0, '0);
            begin
                idle(4);
                out_ready = 1'b1;
            end
        join
        drain();
        idle(2);

        // Flush in FULL with an input offered.
        out_ready = 1'b0;
        send(32'h00100093, 32'h0, 32'd1, 32'd1, 1'b0, '0);
        send(32'h00200113, 32'h0, 32'd2, 32'd2, 1'b0, '0);
        instr = 32'h003001B3; in_valid = 1'b1; flush = 1'b1;
        idle(1);
        flush = 1'b0; in_valid = 1'b0;
        idle(2);
        out_ready = 1'b1;
        idle(2);

        // Flush in ONE with same-cycle accept and consume.
        send(32'h00500293, 32'h0, 32'd5, 32'd5, 1'b0, '0);
        instr = 32'h00600313; in_valid = 1'b1; flush = 1'b1;
        idle(1);
        flush = 1'b0; in_valid = 1'b0;
        idle(2);

        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            instr     = rand_instr();
            pc        = $urandom;
            rs1_data  = $urandom;
            rs2_data  = $urandom;
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 39) == 0);
            idle(1);
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        drain();

        // Asynchronous reset between clock edges while FULL.
        out_ready = 1'b0;
        send(32'h002081B3, 32'h0, 32'd11, 32'd12, 1'b0, '0);
        send(32'h40435293, 32'h0, 32'h80000000, 32'd0, 1'b0, '0);
        #2;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(2);
        drain();
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
